// File: rtl/iq_burst_ctrl.sv
// rtl/iq_burst_ctrl.sv - IQ burst sequencer: input FIFO -> unpack/quantize -> paired I/Q FIFO writes
`timescale 1ns/1ps

module iq_burst_ctrl #(
   parameter int QBITS = 10,
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] burst_len,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic [CNT_W-1:0] sample_count,
   output logic [31:0]      stall_cycles,
   output logic             in_rd_en,
   input  logic             in_empty,
   input  logic [63:0]      in_dout,
   output logic             i_wr_en,
   input  logic             i_full,
   output logic [31:0]      i_din,
   output logic             q_wr_en,
   input  logic             q_full,
   output logic [31:0]      q_din
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_WRITE,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] burst_len_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_inc;
   logic [31:0]      stall_q;
   logic [31:0]      i_q, q_q;
   logic [31:0]      raw_i, raw_q;
   logic [31:0]      i_unp, q_unp;
   logic             busy_q, done_q, aborted_q;
   logic             rd_fire, wr_fire, last_pair;

   // Halves are stored little-half-last in the packed word; the shift wraps by design.
   always_comb begin
      raw_i = {in_dout[47:32], in_dout[63:48]};
      raw_q = {in_dout[15:0], in_dout[31:16]};
      i_unp = raw_i << QBITS;
      q_unp = raw_q << QBITS;
   end

   always_comb begin
      rd_fire   = (state_q == S_FETCH) && !abort && !in_empty;
      wr_fire   = (state_q == S_WRITE) && !i_full && !q_full;
      count_inc = count_q + CNT_W'(1);
      last_pair = (burst_len_q != '0) && (count_inc == burst_len_q);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_FETCH;
         S_FETCH: begin
            if (abort)          state_d = S_DONE;
            else if (!in_empty) state_d = S_WRITE;
         end
         S_WRITE: if (wr_fire) state_d = (last_pair || abort) ? S_DONE : S_FETCH;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         burst_len_q <= '0;
         count_q     <= '0;
         stall_q     <= '0;
         i_q         <= '0;
         q_q         <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         aborted_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d != S_IDLE);
         done_q  <= (state_d == S_DONE);
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  burst_len_q <= burst_len;
                  count_q     <= '0;
                  stall_q     <= '0;
                  aborted_q   <= 1'b0;
               end
            end
            S_FETCH: begin
               if (abort) begin
                  aborted_q <= 1'b1;
               end else if (rd_fire) begin
                  i_q <= i_unp;
                  q_q <= q_unp;
               end
            end
            S_WRITE: begin
               // A final write that coincides with abort counts as a normal finish.
               if (wr_fire) begin
                  count_q <= count_inc;
                  if (!last_pair && abort) aborted_q <= 1'b1;
               end else if (stall_q != 32'hFFFF_FFFF) begin
                  stall_q <= stall_q + 32'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign aborted      = aborted_q;
   assign sample_count = count_q;
   assign stall_cycles = stall_q;
   assign in_rd_en     = rd_fire;
   assign i_wr_en      = wr_fire;
   assign q_wr_en      = wr_fire;
   assign i_din        = wr_fire ? i_q : 32'd0;
   assign q_din        = wr_fire ? q_q : 32'd0;

endmodule

// File: tb/tb_iq_burst_ctrl.sv
// tb/tb_iq_burst_ctrl.sv - directed self-checking bench for iq_burst_ctrl
`timescale 1ns/1ps

module tb_iq_burst_ctrl;

   localparam int CNT_W = 16;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic             in_empty = 1'b1;
   logic             i_full = 1'b0;
   logic             q_full = 1'b0;
   logic [CNT_W-1:0] burst_len = '0;
   logic [63:0]      in_dout = '0;
   logic             busy, done, aborted, in_rd_en, i_wr_en, q_wr_en;
   logic [CNT_W-1:0] sample_count;
   logic [31:0]      stall_cycles, i_din, q_din;

   iq_burst_ctrl #(.QBITS(10), .CNT_W(CNT_W)) dut (
      .clock(clock), .reset(reset), .start(start), .burst_len(burst_len), .abort(abort),
      .busy(busy), .done(done), .aborted(aborted), .sample_count(sample_count),
      .stall_cycles(stall_cycles), .in_rd_en(in_rd_en), .in_empty(in_empty),
      .in_dout(in_dout), .i_wr_en(i_wr_en), .i_full(i_full), .i_din(i_din),
      .q_wr_en(q_wr_en), .q_full(q_full), .q_din(q_din)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int          rd_n = 0, rd_bad = 0, wr_n = 0, wr_bad = 0, split_n = 0, zero_bad = 0;
   int          data_bad = 0, done_n = 0, done_cyc = 0, last_wr_cyc = 0;
   logic        done_ab = 1'b0;
   logic [31:0] exp_i = '0, exp_q = '0;

   always @(negedge clock) begin
      if (in_rd_en) rd_n++;
      if (in_rd_en && in_empty) rd_bad++;
      if (i_wr_en != q_wr_en) split_n++;
      if (!i_wr_en && (i_din != 0 || q_din != 0)) zero_bad++;
      if (i_wr_en) begin
         wr_n++;
         last_wr_cyc = cyc;
         if (i_din !== exp_i || q_din !== exp_q) data_bad++;
         if (i_full || q_full) wr_bad++;
      end
      if (done) begin
         done_n++;
         done_cyc = cyc;
         done_ab  = aborted;
      end
   end

   int n_checks = 0, n_errors = 0;
   int s_cyc = 0, b_rd = 0, b_wr = 0, b_done = 0, b_data = 0, b_wrbad = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic snap();
      b_rd = rd_n; b_wr = wr_n; b_done = done_n; b_data = data_bad; b_wrbad = wr_bad;
   endtask

   task automatic do_start(input logic [CNT_W-1:0] len);
      @(posedge clock); #1;
      start = 1'b1; burst_len = len; s_cyc = cyc;
      @(posedge clock); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      bit found = 1'b0;
      for (int k = 0; k < budget && !found; k++) begin
         @(negedge clock);
         if (done) found = 1'b1;
      end
      check("done_seen", 64'(found), 64'd1);
      @(posedge clock); #1;
   endtask

   initial begin
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_flags", 64'({done, aborted, in_rd_en, i_wr_en, q_wr_en}), 64'd0);
      check("rst_data", {i_din, q_din}, 64'd0);
      check("rst_cnt", {16'd0, sample_count, stall_cycles}, 64'd0);

      // burst of 4, constant word, no backpressure
      in_empty = 1'b0; in_dout = 64'h0001_0000_FFFF_FFFF;
      exp_i = 32'h0000_0400; exp_q = 32'hFFFF_FC00;
      snap(); do_start(16'd4); wait_done(40);
      check("t1_reads", 64'(rd_n - b_rd), 64'd4);
      check("t1_writes", 64'(wr_n - b_wr), 64'd4);
      check("t1_data", 64'(data_bad - b_data), 64'd0);
      check("t1_latency", 64'(done_cyc - s_cyc), 64'd9);
      check("t1_done_after_wr", 64'(done_cyc - last_wr_cyc), 64'd1);
      check("t1_count", 64'(sample_count), 64'd4);
      check("t1_aborted", 64'(done_ab), 64'd0);
      check("t1_busy_idle", 64'(busy), 64'd0);

      // burst of 3, I FIFO full for 5 cycles during second WRITE
      snap(); do_start(16'd3);
      repeat (3) @(posedge clock);
      #1 i_full = 1'b1;
      repeat (5) @(posedge clock);
      #1 i_full = 1'b0;
      wait_done(40);
      check("t2_stall", 64'(stall_cycles), 64'd5);
      check("t2_writes", 64'(wr_n - b_wr), 64'd3);
      check("t2_wr_full", 64'(wr_bad - b_wrbad), 64'd0);
      check("t2_latency", 64'(done_cyc - s_cyc), 64'd12);
      check("t2_count", 64'(sample_count), 64'd3);

      // continuous, abort during 10th WRITE
      in_dout = 64'h0003_FFFF_0002_0000;
      exp_i = 32'hFC00_0C00; exp_q = 32'h0000_0800;
      snap(); do_start(16'd0);
      repeat (19) @(posedge clock);
      #1 abort = 1'b1;
      @(posedge clock);
      #1 abort = 1'b0;
      wait_done(10);
      repeat (4) @(posedge clock);
      #1;
      check("t3_reads", 64'(rd_n - b_rd), 64'd10);
      check("t3_writes", 64'(wr_n - b_wr), 64'd10);
      check("t3_data", 64'(data_bad - b_data), 64'd0);
      check("t3_count", 64'(sample_count), 64'd10);
      check("t3_done_ab", 64'(done_ab), 64'd1);
      check("t3_ab_held", 64'(aborted), 64'd1);
      check("t3_latency", 64'(done_cyc - s_cyc), 64'd21);

      // input empty for 7 cycles after start
      in_empty = 1'b1; in_dout = 64'h0001_0000_FFFF_FFFF;
      exp_i = 32'h0000_0400; exp_q = 32'hFFFF_FC00;
      snap(); do_start(16'd2);
      repeat (7) @(posedge clock);
      #1 in_empty = 1'b0;
      wait_done(40);
      check("t4_reads", 64'(rd_n - b_rd), 64'd2);
      check("t4_stall", 64'(stall_cycles), 64'd0);
      check("t4_latency", 64'(done_cyc - s_cyc), 64'd12);
      check("t4_aborted", 64'(done_ab), 64'd0);
      check("t4_count", 64'(sample_count), 64'd2);

      // reset while WRITE holds the second captured pair
      snap(); do_start(16'd5);
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;
      @(negedge clock);
      check("t5_busy", 64'(busy), 64'd0);
      check("t5_strobes", 64'({i_wr_en, q_wr_en, in_rd_en, done, aborted}), 64'd0);
      check("t5_data", {i_din, q_din}, 64'd0);
      check("t5_count", 64'(sample_count), 64'd0);
      @(posedge clock);
      #1 reset = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check("t5_writes", 64'(wr_n - b_wr), 64'd1);
      check("t5_no_done", 64'(done_n - b_done), 64'd0);
      snap(); do_start(16'd1); wait_done(20);
      check("t5_restart_count", 64'(sample_count), 64'd1);
      check("t5_restart_wr", 64'(wr_n - b_wr), 64'd1);
      check("t5_restart_lat", 64'(done_cyc - s_cyc), 64'd3);

      // start held through burst and DONE; wrap quantization
      in_dout = 64'hFFFF_7FFF_1234_8000;
      exp_i = 32'hFFFF_FC00; exp_q = 32'h0048_D000;
      snap();
      @(posedge clock); #1;
      start = 1'b1; burst_len = 16'd2; s_cyc = cyc;
      repeat (6) @(posedge clock);
      #1 start = 1'b0;
      repeat (5) @(posedge clock);
      #1;
      check("t6_one_done", 64'(done_n - b_done), 64'd1);
      check("t6_writes", 64'(wr_n - b_wr), 64'd2);
      check("t6_wrap_data", 64'(data_bad - b_data), 64'd0);
      check("t6_latency", 64'(done_cyc - s_cyc), 64'd5);
      check("t6_busy", 64'(busy), 64'd0);

      // abort seen in FETCH with empty input
      in_empty = 1'b1;
      snap(); do_start(16'd3);
      abort = 1'b1;
      @(posedge clock);
      #1 abort = 1'b0;
      wait_done(10);
      check("t7_latency", 64'(done_cyc - s_cyc), 64'd2);
      check("t7_reads", 64'(rd_n - b_rd), 64'd0);
      check("t7_done_ab", 64'(done_ab), 64'd1);
      check("t7_count", 64'(sample_count), 64'd0);

      // final write coincides with abort
      in_empty = 1'b0; in_dout = 64'h0001_0000_FFFF_FFFF;
      exp_i = 32'h0000_0400; exp_q = 32'hFFFF_FC00;
      snap(); do_start(16'd1);
      check("t8_ab_cleared", 64'(aborted), 64'd0);
      @(posedge clock);
      #1 abort = 1'b1;
      @(posedge clock);
      #1 abort = 1'b0;
      wait_done(10);
      check("t8_done_ab", 64'(done_ab), 64'd0);
      check("t8_count", 64'(sample_count), 64'd1);
      check("t8_writes", 64'(wr_n - b_wr), 64'd1);

      check("rd_while_empty", 64'(rd_bad), 64'd0);
      check("split_strobes", 64'(split_n), 64'd0);
      check("idle_data_zero", 64'(zero_bad), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
